// File: rtl/fish_pkg.sv
// rtl/fish_pkg.sv - shared types and constants for the fish game score path
package fish_pkg;

    localparam int NUM_FISH  = 9;
    localparam int SCORE_W   = 10;

    typedef logic [SCORE_W-1:0] score_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        OVER = 2'd2
    } score_state_t;

    typedef enum logic [1:0] {
        WIN_NONE  = 2'b00,
        WIN_USER1 = 2'b01,
        WIN_USER2 = 2'b10,
        WIN_TIE   = 2'b11
    } winner_t;

    // Clamp an 11-bit running sum into the 10-bit score range
    function automatic score_t sat_score(input logic [SCORE_W:0] sum);
        if (sum[SCORE_W]) begin
            return '1;
        end
        return sum[SCORE_W-1:0];
    endfunction

endpackage

// File: rtl/score_bcd.sv
// rtl/score_bcd.sv - registered 10-bit binary to three-digit BCD converter
module score_bcd (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [9:0]  i_bin,
    output logic [11:0] o_bcd
);

    logic [21:0] w_dd;
    logic [11:0] r_bcd;

    // Double-dabble: add 3 to any digit >= 5, then shift in the next binary bit
    always_comb begin
        w_dd = {12'd0, i_bin};
        for (int i = 0; i < 10; i++) begin
            if (w_dd[13:10] >= 4'd5) w_dd[13:10] = w_dd[13:10] + 4'd3;
            if (w_dd[17:14] >= 4'd5) w_dd[17:14] = w_dd[17:14] + 4'd3;
            if (w_dd[21:18] >= 4'd5) w_dd[21:18] = w_dd[21:18] + 4'd3;
            w_dd = w_dd << 1;
        end
    end

    // Register the converted digits for the display drivers
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_bcd <= '0;
        end else begin
            r_bcd <= w_dd[21:10];
        end
    end

    assign o_bcd = r_bcd;

endmodule

// File: rtl/fish_score.sv
// rtl/fish_score.sv - per-player score, level and win tracking (FISH_SCORE_BCD_EN adds BCD score outputs)
module fish_score #(
    parameter int NUM_FISH   = fish_pkg::NUM_FISH,
    parameter int POINTS     = 1,
    parameter int LVL1_SCORE = 5,
    parameter int LVL2_SCORE = 15,
    parameter int LVL3_SCORE = 30,
    parameter int WIN_SCORE  = 40
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                is_start,
    input  logic [NUM_FISH-1:0] user1_eat,
    input  logic [NUM_FISH-1:0] user2_eat,
    output logic [9:0]          user1_score,
    output logic [9:0]          user2_score,
    output logic [1:0]          user1_level,
    output logic [1:0]          user2_level,
    output logic                playing,
    output logic                game_over,
    output logic [1:0]          winner
`ifdef FISH_SCORE_BCD_EN
    ,
    output logic [11:0]         user1_score_bcd,
    output logic [11:0]         user2_score_bcd
`endif
);

    import fish_pkg::*;

    localparam score_t      LVL1_S = score_t'(LVL1_SCORE);
    localparam score_t      LVL2_S = score_t'(LVL2_SCORE);
    localparam score_t      LVL3_S = score_t'(LVL3_SCORE);
    localparam score_t      WIN_S  = score_t'(WIN_SCORE);
    localparam logic [10:0] PTS    = 11'(POINTS);

    score_state_t        r_state;
    logic                r_is_start_q;
    logic                r_playing;
    logic                r_game_over;
    logic [NUM_FISH-1:0] r_eat1_q;
    logic [NUM_FISH-1:0] r_eat2_q;
    score_t              r_score1;
    score_t              r_score2;
    logic [1:0]          r_level1;
    logic [1:0]          r_level2;
    winner_t             r_winner;

    logic                w_start_rise;
    logic [NUM_FISH-1:0] w_edge1;
    logic [NUM_FISH-1:0] w_edge2;
    logic [3:0]          w_cnt1;
    logic [3:0]          w_cnt2;
    logic [10:0]         w_sum1;
    logic [10:0]         w_sum2;
    score_t              w_next1;
    score_t              w_next2;
    logic                w_win1;
    logic                w_win2;

    function automatic logic [1:0] level_of(input score_t s);
        if (s >= LVL3_S) return 2'd3;
        if (s >= LVL2_S) return 2'd2;
        if (s >= LVL1_S) return 2'd1;
        return 2'd0;
    endfunction

    // A held overlap only counts on its first cycle
    assign w_start_rise = is_start & ~r_is_start_q;
    assign w_edge1      = user1_eat & ~r_eat1_q;
    assign w_edge2      = user2_eat & ~r_eat2_q;

    // Count newly eaten fish for each player this cycle
    always_comb begin
        w_cnt1 = '0;
        w_cnt2 = '0;
        for (int i = 0; i < NUM_FISH; i++) begin
            w_cnt1 = w_cnt1 + 4'(w_edge1[i]);
            w_cnt2 = w_cnt2 + 4'(w_edge2[i]);
        end
    end

    assign w_sum1  = {1'b0, r_score1} + 11'(w_cnt1) * PTS;
    assign w_sum2  = {1'b0, r_score2} + 11'(w_cnt2) * PTS;
    assign w_next1 = sat_score(w_sum1);
    assign w_next2 = sat_score(w_sum2);

    // The game ends on the registered scores, one cycle after the threshold is reached
    assign w_win1  = (r_score1 >= WIN_S);
    assign w_win2  = (r_score2 >= WIN_S);

    // Game state machine with scoring, levels and winner held in registers
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state      <= IDLE;
            r_is_start_q <= 1'b0;
            r_playing    <= 1'b0;
            r_game_over  <= 1'b0;
            r_eat1_q     <= '0;
            r_eat2_q     <= '0;
            r_score1     <= '0;
            r_score2     <= '0;
            r_level1     <= 2'd0;
            r_level2     <= 2'd0;
            r_winner     <= WIN_NONE;
        end else begin
            r_is_start_q <= is_start;
            r_eat1_q     <= user1_eat;
            r_eat2_q     <= user2_eat;
            case (r_state)
                IDLE, OVER: begin
                    if (w_start_rise) begin
                        r_state     <= PLAY;
                        r_playing   <= 1'b1;
                        r_game_over <= 1'b0;
                        r_score1    <= '0;
                        r_score2    <= '0;
                        r_level1    <= 2'd0;
                        r_level2    <= 2'd0;
                        r_winner    <= WIN_NONE;
                    end
                end
                PLAY: begin
                    r_score1 <= w_next1;
                    r_score2 <= w_next2;
                    r_level1 <= level_of(w_next1);
                    r_level2 <= level_of(w_next2);
                    if (w_win1 || w_win2) begin
                        r_state     <= OVER;
                        r_playing   <= 1'b0;
                        r_game_over <= 1'b1;
                        r_winner    <= winner_t'({w_win2, w_win1});
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_playing   <= 1'b0;
                    r_game_over <= 1'b0;
                end
            endcase
        end
    end

    assign user1_score = r_score1;
    assign user2_score = r_score2;
    assign user1_level = r_level1;
    assign user2_level = r_level2;
    assign playing     = r_playing;
    assign game_over   = r_game_over;
    assign winner      = r_winner;

`ifdef FISH_SCORE_BCD_EN
    score_bcd u_bcd1 (
        .Clk   (Clk),
        .Reset (Reset),
        .i_bin (r_score1),
        .o_bcd (user1_score_bcd)
    );

    score_bcd u_bcd2 (
        .Clk   (Clk),
        .Reset (Reset),
        .i_bin (r_score2),
        .o_bcd (user2_score_bcd)
    );
`endif

endmodule

// File: tb/tb_fish_score.sv
// tb/tb_fish_score.sv - self-checking bench for fish_score
module tb_fish_score;

    localparam int NF  = 9;
    localparam int PTS = 1;
    localparam int L1  = 5;
    localparam int L2  = 15;
    localparam int L3  = 30;
    localparam int WIN = 40;

    logic          Clk = 1'b0;
    logic          Reset = 1'b0;
    logic          is_start = 1'b0;
    logic [NF-1:0] user1_eat = '0;
    logic [NF-1:0] user2_eat = '0;
    logic [9:0]    user1_score;
    logic [9:0]    user2_score;
    logic [1:0]    user1_level;
    logic [1:0]    user2_level;
    logic          playing;
    logic          game_over;
    logic [1:0]    winner;
`ifdef FISH_SCORE_BCD_EN
    logic [11:0]   user1_score_bcd;
    logic [11:0]   user2_score_bcd;
`endif

    fish_score #(
        .NUM_FISH   (NF),
        .POINTS     (PTS),
        .LVL1_SCORE (L1),
        .LVL2_SCORE (L2),
        .LVL3_SCORE (L3),
        .WIN_SCORE  (WIN)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .is_start    (is_start),
        .user1_eat   (user1_eat),
        .user2_eat   (user2_eat),
        .user1_score (user1_score),
        .user2_score (user2_score),
        .user1_level (user1_level),
        .user2_level (user2_level),
        .playing     (playing),
        .game_over   (game_over),
        .winner      (winner)
`ifdef FISH_SCORE_BCD_EN
        ,
        .user1_score_bcd (user1_score_bcd),
        .user2_score_bcd (user2_score_bcd)
`endif
    );

    always #10 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int            m_s1, m_s2, m_p1, m_p2, m_w;
    bit            m_play, m_over, m_start_q;
    logic [NF-1:0] m_e1q, m_e2q;

    typedef struct packed {
        logic          st;
        logic [NF-1:0] e1;
        logic [NF-1:0] e2;
        logic [9:0]    s1;
        logic [9:0]    s2;
        logic [1:0]    l1;
        logic [1:0]    l2;
        logic          pl;
        logic          ov;
        logic [1:0]    w;
    } vec_t;

    vec_t tbl [0:30];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int lvl(input int s);
        if (s >= L3) return 3;
        if (s >= L2) return 2;
        if (s >= L1) return 1;
        return 0;
    endfunction

    function automatic int to_bcd(input int s);
        return ((s / 100) << 8) | (((s / 10) % 10) << 4) | (s % 10);
    endfunction

    task automatic model_reset();
        m_s1 = 0; m_s2 = 0; m_p1 = 0; m_p2 = 0; m_w = 0;
        m_play = 0; m_over = 0; m_start_q = 0;
        m_e1q = '0; m_e2q = '0;
    endtask

    task automatic model_clock(input bit st, input logic [NF-1:0] a, input logic [NF-1:0] b);
        int  c1, c2;
        bit  rise, w1, w2;
        c1   = $countones(a & ~m_e1q);
        c2   = $countones(b & ~m_e2q);
        rise = st & ~m_start_q;
        m_start_q = st; m_e1q = a; m_e2q = b;
        m_p1 = m_s1; m_p2 = m_s2;
        if (m_play) begin
            w1 = (m_s1 >= WIN);
            w2 = (m_s2 >= WIN);
            m_s1 = (m_s1 + c1 * PTS > 1023) ? 1023 : m_s1 + c1 * PTS;
            m_s2 = (m_s2 + c2 * PTS > 1023) ? 1023 : m_s2 + c2 * PTS;
            if (w1 || w2) begin
                m_play = 0;
                m_over = 1;
                m_w    = (w2 ? 2 : 0) + (w1 ? 1 : 0);
            end
        end else if (rise) begin
            m_play = 1; m_over = 0;
            m_s1 = 0; m_s2 = 0; m_w = 0;
        end
    endtask

    // Called at a falling edge: drive, clock once, then return at the next falling edge
    task automatic step(input bit st, input logic [NF-1:0] a, input logic [NF-1:0] b);
        is_start  = st;
        user1_eat = a;
        user2_eat = b;
        @(posedge Clk);
        model_clock(st, a, b);
        @(negedge Clk);
    endtask

    task automatic check_const(input string tag, input int s1, input int s2, input int l1,
                               input int l2, input int pl, input int ov, input int w);
        chk({tag, ".score1"}, int'(user1_score), s1);
        chk({tag, ".score2"}, int'(user2_score), s2);
        chk({tag, ".level1"}, int'(user1_level), l1);
        chk({tag, ".level2"}, int'(user2_level), l2);
        chk({tag, ".playing"}, int'(playing), pl);
        chk({tag, ".game_over"}, int'(game_over), ov);
        chk({tag, ".winner"}, int'(winner), w);
    endtask

    task automatic check_model(input string tag);
        check_const(tag, m_s1, m_s2, lvl(m_s1), lvl(m_s2), int'(m_play), int'(m_over), m_w);
`ifdef FISH_SCORE_BCD_EN
        chk({tag, ".bcd1"}, int'(user1_score_bcd), to_bcd(m_p1));
        chk({tag, ".bcd2"}, int'(user2_score_bcd), to_bcd(m_p2));
`endif
    endtask

    initial begin
        //          st  e1       e2       s1  s2 l1 l2 pl ov w
        tbl[0]  = '{1'b1, 9'h000, 9'h000, 10'd0,  10'd0,  2'd0, 2'd0, 1'b1, 1'b0, 2'd0};
        tbl[1]  = '{1'b0, 9'h001, 9'h000, 10'd1,  10'd0,  2'd0, 2'd0, 1'b1, 1'b0, 2'd0};
        tbl[2]  = '{1'b0, 9'h001, 9'h000, 10'd1,  10'd0,  2'd0, 2'd0, 1'b1, 1'b0, 2'd0};
        tbl[3]  = '{1'b0, 9'h001, 9'h000, 10'd1,  10'd0,  2'd0, 2'd0, 1'b1, 1'b0, 2'd0};
        tbl[4]  = '{1'b0, 9'h001, 9'h000, 10'd1,  10'd0,  2'd0, 2'd0, 1'b1, 1'b0, 2'd0};
        tbl[5]  = '{1'b0, 9'h001, 9'h000, 10'd1,  10'd0,  2'd0, 2'd0, 1'b1, 1'b0, 2'd0};
        tbl[6]  = '{1'b0, 9'h000, 9'h000, 10'd1,  10'd0,  2'd0, 2'd0, 1'b1, 1'b0, 2'd0};
        tbl[7]  = '{1'b0, 9'h1FF, 9'h000, 10'd10, 10'd0,  2'd1, 2'd0, 1'b1, 1'b0, 2'd0};
        tbl[8]  = '{1'b0, 9'h000, 9'h000, 10'd10, 10'd0,  2'd1, 2'd0, 1'b1, 1'b0, 2'd0};
        tbl[9]  = '{1'b0, 9'h008, 9'h008, 10'd11, 10'd1,  2'd1, 2'd0, 1'b1, 1'b0, 2'd0};
        tbl[10] = '{1'b0, 9'h000, 9'h000, 10'd11, 10'd1,  2'd1, 2'd0, 1'b1, 1'b0, 2'd0};
        tbl[11] = '{1'b0, 9'h000, 9'h00E, 10'd11, 10'd4,  2'd1, 2'd0, 1'b1, 1'b0, 2'd0};
        tbl[12] = '{1'b0, 9'h000, 9'h000, 10'd11, 10'd4,  2'd1, 2'd0, 1'b1, 1'b0, 2'd0};
        tbl[13] = '{1'b0, 9'h000, 9'h001, 10'd11, 10'd5,  2'd1, 2'd1, 1'b1, 1'b0, 2'd0};
        tbl[14] = '{1'b0, 9'h000, 9'h000, 10'd11, 10'd5,  2'd1, 2'd1, 1'b1, 1'b0, 2'd0};
        tbl[15] = '{1'b0, 9'h000, 9'h1FF, 10'd11, 10'd14, 2'd1, 2'd1, 1'b1, 1'b0, 2'd0};
        tbl[16] = '{1'b0, 9'h000, 9'h000, 10'd11, 10'd14, 2'd1, 2'd1, 1'b1, 1'b0, 2'd0};
        tbl[17] = '{1'b0, 9'h000, 9'h001, 10'd11, 10'd15, 2'd1, 2'd2, 1'b1, 1'b0, 2'd0};
        tbl[18] = '{1'b0, 9'h000, 9'h000, 10'd11, 10'd15, 2'd1, 2'd2, 1'b1, 1'b0, 2'd0};
        tbl[19] = '{1'b0, 9'h1FF, 9'h000, 10'd20, 10'd15, 2'd2, 2'd2, 1'b1, 1'b0, 2'd0};
        tbl[20] = '{1'b0, 9'h000, 9'h000, 10'd20, 10'd15, 2'd2, 2'd2, 1'b1, 1'b0, 2'd0};
        tbl[21] = '{1'b0, 9'h1FF, 9'h000, 10'd29, 10'd15, 2'd2, 2'd2, 1'b1, 1'b0, 2'd0};
        tbl[22] = '{1'b0, 9'h000, 9'h000, 10'd29, 10'd15, 2'd2, 2'd2, 1'b1, 1'b0, 2'd0};
        tbl[23] = '{1'b0, 9'h1FF, 9'h000, 10'd38, 10'd15, 2'd3, 2'd2, 1'b1, 1'b0, 2'd0};
        tbl[24] = '{1'b0, 9'h000, 9'h000, 10'd38, 10'd15, 2'd3, 2'd2, 1'b1, 1'b0, 2'd0};
        tbl[25] = '{1'b0, 9'h003, 9'h000, 10'd40, 10'd15, 2'd3, 2'd2, 1'b1, 1'b0, 2'd0};
        tbl[26] = '{1'b0, 9'h000, 9'h000, 10'd40, 10'd15, 2'd3, 2'd2, 1'b0, 1'b1, 2'd1};
        tbl[27] = '{1'b0, 9'h1FF, 9'h1FF, 10'd40, 10'd15, 2'd3, 2'd2, 1'b0, 1'b1, 2'd1};
        tbl[28] = '{1'b1, 9'h000, 9'h000, 10'd0,  10'd0,  2'd0, 2'd0, 1'b1, 1'b0, 2'd0};
        tbl[29] = '{1'b0, 9'h000, 9'h000, 10'd0,  10'd0,  2'd0, 2'd0, 1'b1, 1'b0, 2'd0};
        tbl[30] = '{1'b1, 9'h000, 9'h000, 10'd0,  10'd0,  2'd0, 2'd0, 1'b1, 1'b0, 2'd0};

        model_reset();
        repeat (2) @(negedge Clk);
        check_const("reset", 0, 0, 0, 0, 0, 0, 0);
        Reset = 1'b1;
        step(1'b0, '0, '0);
        check_const("idle", 0, 0, 0, 0, 0, 0, 0);

        // Directed scenario from a fresh game through win and restart
        for (int k = 0; k < 31; k++) begin
            step(tbl[k].st, tbl[k].e1, tbl[k].e2);
            check_const($sformatf("tbl%0d", k), int'(tbl[k].s1), int'(tbl[k].s2),
                        int'(tbl[k].l1), int'(tbl[k].l2), int'(tbl[k].pl),
                        int'(tbl[k].ov), int'(tbl[k].w));
        end
        step(1'b0, '0, '0);

        // Both players reach the win score in the same cycle
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 9'h1FF, 9'h1FF);
            step(1'b0, 9'h000, 9'h000);
        end
        step(1'b0, 9'h007, 9'h007);
        check_const("tie39", 39, 39, 3, 3, 1, 0, 0);
        step(1'b0, 9'h000, 9'h000);
        step(1'b0, 9'h001, 9'h001);
        check_model("tie40");
        step(1'b0, 9'h000, 9'h000);
        check_const("tie_over", 40, 40, 3, 3, 0, 1, 3);

        // Asynchronous reset in the middle of a game
        step(1'b1, 9'h000, 9'h000);
        step(1'b0, 9'h0FF, 9'h000);
        check_model("pre_rst");
        #3 Reset = 1'b0;
        #1 check_const("async_rst", 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        @(negedge Clk);
        Reset = 1'b1;
        step(1'b0, 9'h1FF, 9'h1FF);
        check_const("post_rst_idle", 0, 0, 0, 0, 0, 0, 0);
        step(1'b0, 9'h000, 9'h000);
        check_model("post_rst_idle2");

        // Randomized play against the reference model
        for (int k = 0; k < 3000; k++) begin
            step($urandom_range(0, 15) == 0,
                 NF'($urandom & $urandom & $urandom),
                 NF'($urandom & $urandom & $urandom));
            check_model($sformatf("rnd%0d", k));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
